dmem_responder: RTL and testbench

Data-memory responder for the sequential Y86-64 datapath: the target end of the memory stage's load/store requests (mrmovq, rmmovq, pushq, popq, call, ret). It accepts one request at a time over a valid/ready handshake and applies a programmable access latency. It holds byte-addressed little-endian storage, performs 64-bit reads and writes at any byte alignment, and flags out-of-range accesses as a memory error for the status logic.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the Y86-64 memory stage: one request at a time over
// valid/ready, programmable access latency, byte-addressed little-endian storage.
module dmem_responder #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] LastAddr = 64'(MEM_BYTES) - 64'd8;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        commit;
    logic        addr_err;
    logic [AW-1:0] idx;
    logic [63:0] mem_rd;

    // Storage is deliberately left out of reset.
    logic [7:0]  mem [MEM_BYTES];

    // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
    assign addr_err = (addr_q > LastAddr);
    assign idx      = addr_q[AW-1:0];

    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 8; i++) begin
            mem_rd[8*i +: 8] = mem[idx + AW'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Counter expiry marks the single commit edge of the request.
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    rdata_d = (addr_err || write_q) ? 64'd0 : mem_rd;
                    error_d = addr_err;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // While rst_n is low the FSM sits in StIdle, so an abandoned store never commits.
    always_ff @(posedge clk) begin
        if (commit && write_q && !addr_err) begin
            for (int i = 0; i < 8; i++) begin
                mem[idx + AW'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_dmem_responder;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [63:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, rsp_ready0 = 1'b1;
    logic [63:0] req_addr0 = '0, req_wdata0 = '0;
    logic        req_ready0, rsp_valid0, rsp_error0;
    logic [63:0] rsp_rdata0;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    dmem_responder #(.MEM_BYTES(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    dmem_responder #(.MEM_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard", rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_error", {63'd0, rsp_error}, {63'd0, mon_e.err});
            end
        end
    end

    task automatic push_exp(input logic [63:0] rd, input logic er);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    // Drive a request and return just after the accepting edge; inputs are then scrambled.
    task automatic accept(input logic w, input logic [63:0] a, input logic [63:0] d);
        int n = 0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got rsp_valid 0 expected 1");
        end
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] er, input logic ee);
        push_exp(er, ee);
        accept(w, a, d);
        wait_rsp();
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] Pat = 64'h0123456789ABCDEF;
    localparam logic [63:0] Top = 64'h1122334455667788;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_error", {63'd0, rsp_error}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic store/load and unaligned load straddling two words.
        issue(1'b1, 64'h100, Pat, 64'd0, 1'b0);
        issue(1'b0, 64'h100, 64'd0, Pat, 1'b0);
        issue(1'b1, 64'h108, 64'd0, 64'd0, 1'b0);
        issue(1'b1, 64'h100, Pat, 64'd0, 1'b0);
        issue(1'b0, 64'h101, 64'd0, 64'h000123456789ABCD, 1'b0);

        // Latency with WAIT_CYCLES=2: accept at edge 0, valid after edge 3.
        push_exp(Pat, 1'b0);
        req_write = 1'b0;
        req_addr  = 64'h100;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat2_rsp_valid_e%0d", k), {63'd0, rsp_valid}, (k == 3) ? 64'd1 : 64'd0);
            check($sformatf("lat2_req_ready_e%0d", k), {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1;

        // Latency with WAIT_CYCLES=0: valid after edge 1.
        req_write0 = 1'b1;
        req_addr0  = 64'h10;
        req_wdata0 = 64'h77;
        req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        check("lat0_rsp_valid_e0", {63'd0, rsp_valid0}, 64'd0);
        @(posedge clk); #1;
        check("lat0_rsp_valid_e1", {63'd0, rsp_valid0}, 64'd1);
        check("lat0_rsp_error", {63'd0, rsp_error0}, 64'd0);
        check("lat0_rsp_rdata", rsp_rdata0, 64'd0);
        @(posedge clk); #1;

        // Range boundary around MEM_BYTES-8.
        issue(1'b1, 64'h3F8, Top, 64'd0, 1'b0);
        issue(1'b0, 64'h3F8, 64'd0, Top, 1'b0);
        issue(1'b1, 64'h3F9, 64'hAAAAAAAAAAAAAAAA, 64'd0, 1'b1);
        issue(1'b0, 64'h3F8, 64'd0, Top, 1'b0);
        issue(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1);
        issue(1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1);

        // Backpressure: response held for 5 cycles while a new request is offered.
        rsp_ready = 1'b0;
        push_exp(Pat, 1'b0);
        accept(1'b0, 64'h100, 64'd0);
        wait_rsp();
        req_write = 1'b1;
        req_addr  = 64'h100;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", rsp_rdata, Pat);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_req_ready", {63'd0, req_ready}, 64'd1);
        check("bp_release_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        issue(1'b0, 64'h100, 64'd0, Pat, 1'b0);

        // Reset during BUSY abandons the store.
        issue(1'b1, 64'h200, 64'h5555, 64'd0, 1'b0);
        issue(1'b0, 64'h200, 64'd0, 64'h5555, 1'b0);
        accept(1'b1, 64'h200, 64'hFFFF);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("midrst_rsp_rdata", rsp_rdata, 64'd0);
        check("midrst_rsp_error", {63'd0, rsp_error}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 64'h200, 64'd0, 64'h5555, 1'b0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
